// File: rtl/piano_key_conditioner.sv
// Piano key input conditioner: sync + debounce of 7 notes and 2 octave
// buttons, last-pressed-wins one-hot key, octave FSM and note event pulse.
module piano_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key_raw,
  input  logic       oct_up_raw,
  input  logic       oct_dn_raw,
  output logic [6:0] key,
  output logic [1:0] pitch,
  output logic       key_event
);

  localparam int N = 9;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MID  = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10
  } oct_t;

  logic [N-1:0]     w_raw;
  logic [N-1:0]     r_s1;
  logic [N-1:0]     r_s2;
  logic [N-1:0]     r_db;
  logic [N-1:0]     r_db_q;
  logic [CNT_W-1:0] r_cnt [N];

  logic [6:0] r_key;
  oct_t       r_oct;
  logic       r_evt;

  logic [6:0] w_k_db;
  logic [6:0] w_k_rise;
  logic       w_up_rise;
  logic       w_dn_rise;
  logic [6:0] w_key_nxt;
  logic       w_oct_chg;

  assign w_raw = {oct_dn_raw, oct_up_raw, key_raw};

  function automatic logic [6:0] f_lowest(input logic [6:0] v);
    return v & (~v + 7'd1);
  endfunction

  // A mismatch must persist DEBOUNCE_CYCLES cycles; any match restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_q <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      for (int i = 0; i < N; i++) begin
        if (r_s2[i] != r_db[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_db[i]  <= r_s2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_k_db    = r_db[6:0];
  assign w_k_rise  = r_db[6:0] & ~r_db_q[6:0];
  assign w_up_rise = r_db[7] & ~r_db_q[7];
  assign w_dn_rise = r_db[8] & ~r_db_q[8];

  always_comb begin
    w_key_nxt = r_key;
    if (|w_k_rise)
      w_key_nxt = f_lowest(w_k_rise);
    else if (|(r_key & ~w_k_db))
      w_key_nxt = f_lowest(w_k_db);
  end

  assign w_oct_chg =
    (w_up_rise & ~w_dn_rise & (r_oct != HIGH)) |
    (w_dn_rise & ~w_up_rise & (r_oct != LOW));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key <= '0;
      r_oct <= MID;
      r_evt <= 1'b0;
    end else begin
      r_key <= w_key_nxt;
      r_evt <= (w_key_nxt != 7'd0) &&
               ((w_key_nxt != r_key) || w_oct_chg);
      if (w_up_rise && !w_dn_rise) begin
        unique case (r_oct)
          LOW:     r_oct <= MID;
          MID:     r_oct <= HIGH;
          default: r_oct <= HIGH;
        endcase
      end else if (w_dn_rise && !w_up_rise) begin
        unique case (r_oct)
          HIGH:    r_oct <= MID;
          MID:     r_oct <= LOW;
          default: r_oct <= LOW;
        endcase
      end
    end
  end

  assign key       = r_key;
  assign pitch     = r_oct;
  assign key_event = r_evt;

endmodule

// File: tb/tb_piano_key_conditioner.sv
// Phase-table bench for piano_key_conditioner with DEBOUNCE_CYCLES=4:
// each phase holds inputs N cycles, then checks key, pitch, event count.
module tb_piano_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] key_raw;
  logic       oct_up_raw;
  logic       oct_dn_raw;
  logic [6:0] key;
  logic [1:0] pitch;
  logic       key_event;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piano_key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_raw(key_raw),
    .oct_up_raw(oct_up_raw),
    .oct_dn_raw(oct_dn_raw),
    .key(key),
    .pitch(pitch),
    .key_event(key_event)
  );

  typedef struct {
    logic       r;
    logic [6:0] kr;
    logic       up;
    logic       dn;
    int         cyc;
    logic [6:0] ekey;
    logic [1:0] ep;
    int         nevt;
  } vec_t;

  typedef struct {
    logic [6:0] ekey;
    logic [1:0] ep;
    int         nevt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic r, input logic [6:0] kr,
    input logic up, input logic dn, input int cyc,
    input logic [6:0] ekey, input logic [1:0] ep,
    input int nevt);
    vec_t v;
    v.r = r; v.kr = kr; v.up = up; v.dn = dn;
    v.cyc = cyc; v.ekey = ekey; v.ep = ep;
    v.nevt = nevt;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic phase(input string nm, input vec_t v);
    exp_t e;
    exp_t got;
    int   ne;
    ne = 0;
    rst        = v.r;
    key_raw    = v.kr;
    oct_up_raw = v.up;
    oct_dn_raw = v.dn;
    e.ekey = v.ekey;
    e.ep   = v.ep;
    e.nevt = v.nevt;
    sb.push_back(e);
    repeat (v.cyc) begin
      @(posedge clk);
      @(negedge clk);
      if (key_event === 1'b1) ne++;
      chk({nm, " onehot"}, int'($countones(key) <= 1), 1);
      chk({nm, " pitch11"}, int'(pitch != 2'b11), 1);
    end
    got = sb.pop_front();
    chk({nm, " key"}, int'(key), int'(got.ekey));
    chk({nm, " pitch"}, int'(pitch), int'(got.ep));
    chk({nm, " events"}, ne, got.nevt);
  endtask

  initial begin
    rst = 1'b1;
    key_raw = '0;
    oct_up_raw = 1'b0;
    oct_dn_raw = 1'b0;

    // reset with all keys held, then exact 7-edge latency
    tbl.push_back(mk(1, 7'h7F, 0, 0, 3, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h7F, 0, 0, 6, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h7F, 0, 0, 1, 7'h01, 2'b00, 1));
    tbl.push_back(mk(0, 7'h7F, 0, 0, 3, 7'h01, 2'b00, 0));
    tbl.push_back(mk(0, 7'h00, 0, 0, 10, 7'h00, 2'b00, 0));
    // short glitch on bit2, then a genuine press
    tbl.push_back(mk(0, 7'h04, 0, 0, 3, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h00, 0, 0, 10, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h04, 0, 0, 6, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h04, 0, 0, 1, 7'h04, 2'b00, 1));
    tbl.push_back(mk(0, 7'h00, 0, 0, 8, 7'h00, 2'b00, 0));
    // last pressed wins
    tbl.push_back(mk(0, 7'h02, 0, 0, 7, 7'h02, 2'b00, 1));
    tbl.push_back(mk(0, 7'h22, 0, 0, 7, 7'h20, 2'b00, 1));
    tbl.push_back(mk(0, 7'h02, 0, 0, 7, 7'h02, 2'b00, 1));
    tbl.push_back(mk(0, 7'h00, 0, 0, 7, 7'h00, 2'b00, 0));
    // simultaneous press
    tbl.push_back(mk(0, 7'h48, 0, 0, 7, 7'h08, 2'b00, 1));
    tbl.push_back(mk(0, 7'h40, 0, 0, 7, 7'h40, 2'b00, 1));
    tbl.push_back(mk(0, 7'h00, 0, 0, 7, 7'h00, 2'b00, 0));
    // octave saturation with key 04 held
    tbl.push_back(mk(0, 7'h04, 0, 0, 7, 7'h04, 2'b00, 1));
    tbl.push_back(mk(0, 7'h04, 1, 0, 7, 7'h04, 2'b10, 1));
    tbl.push_back(mk(0, 7'h04, 0, 0, 7, 7'h04, 2'b10, 0));
    tbl.push_back(mk(0, 7'h04, 1, 0, 7, 7'h04, 2'b10, 0));
    tbl.push_back(mk(0, 7'h04, 0, 0, 7, 7'h04, 2'b10, 0));
    tbl.push_back(mk(0, 7'h04, 1, 0, 7, 7'h04, 2'b10, 0));
    tbl.push_back(mk(0, 7'h04, 0, 0, 7, 7'h04, 2'b10, 0));
    tbl.push_back(mk(0, 7'h04, 0, 1, 7, 7'h04, 2'b00, 1));
    tbl.push_back(mk(0, 7'h04, 0, 0, 7, 7'h04, 2'b00, 0));
    tbl.push_back(mk(0, 7'h04, 0, 1, 7, 7'h04, 2'b01, 1));
    tbl.push_back(mk(0, 7'h04, 0, 0, 7, 7'h04, 2'b01, 0));
    tbl.push_back(mk(0, 7'h04, 0, 1, 7, 7'h04, 2'b01, 0));
    tbl.push_back(mk(0, 7'h04, 0, 0, 7, 7'h04, 2'b01, 0));
    // pitch change while silent, then up+down together
    tbl.push_back(mk(0, 7'h00, 0, 0, 7, 7'h00, 2'b01, 0));
    tbl.push_back(mk(0, 7'h00, 1, 0, 7, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h00, 0, 0, 7, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h00, 1, 1, 7, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h00, 0, 0, 7, 7'h00, 2'b00, 0));
    // reset mid-operation with bit0 partly debounced
    tbl.push_back(mk(0, 7'h10, 0, 0, 7, 7'h10, 2'b00, 1));
    tbl.push_back(mk(0, 7'h10, 1, 0, 7, 7'h10, 2'b10, 1));
    tbl.push_back(mk(0, 7'h10, 0, 0, 7, 7'h10, 2'b10, 0));
    tbl.push_back(mk(0, 7'h11, 0, 0, 4, 7'h10, 2'b10, 0));
    tbl.push_back(mk(1, 7'h11, 0, 0, 1, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h11, 0, 0, 6, 7'h00, 2'b00, 0));
    tbl.push_back(mk(0, 7'h11, 0, 0, 1, 7'h01, 2'b00, 1));
    tbl.push_back(mk(0, 7'h00, 0, 0, 10, 7'h00, 2'b00, 0));

    foreach (tbl[i])
      phase($sformatf("v%0d", i), tbl[i]);

    // glitch interrupted mid-count must restart the count
    phase("rst_a", mk(0, 7'h04, 0, 0, 3, 7'h00, 2'b00, 0));
    phase("rst_b", mk(0, 7'h00, 0, 0, 1, 7'h00, 2'b00, 0));
    phase("rst_c", mk(0, 7'h04, 0, 0, 3, 7'h00, 2'b00, 0));
    phase("rst_d", mk(0, 7'h00, 0, 0, 10, 7'h00, 2'b00, 0));

    // long hold of up must not auto-repeat
    phase("hold_k", mk(0, 7'h08, 0, 0, 7, 7'h08, 2'b00, 1));
    phase("hold_u", mk(0, 7'h08, 1, 0, 40, 7'h08, 2'b10, 1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
